// File: rtl/if_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// tracking, 2-entry instruction buffer and branch redirect with stale-drop.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_ready,
  input  logic        br,
  input  logic [31:0] br_location,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc
);

  logic [31:0] fetch_pc;
  logic [31:0] buf_word [2];
  logic [31:0] buf_pc   [2];
  logic        buf_head;
  logic [1:0]  buf_count;
  logic [31:0] inf_pc   [2];
  logic        inf_head;
  logic [1:0]  outstanding;
  logic [1:0]  drop_count;

  logic        consume;
  logic        redirect;
  logic        req_fire;
  logic        rsp_take;
  logic        rsp_keep;
  logic [2:0]  used;
  logic [1:0]  outstanding_next;
  logic [31:0] target;

  always_comb begin
    instr_valid = buf_count != 2'd0;
    instruction = instr_valid ? buf_word[buf_head] : NOP_INSTR;
    pc          = instr_valid ? buf_pc[buf_head] : '0;
    consume     = instr_valid && id_ready;
    redirect    = consume && br;
    target      = br_location & 32'hFFFF_FFFC;
    // The slot freed by this cycle's consume counts as a credit, so a
    // 1-cycle memory sustains one instruction per cycle.
    used = {1'b0, buf_count} + {1'b0, outstanding} - {2'b00, consume};
    imem_req_valid   = !reset && !redirect && (used < 3'd2);
    imem_req_addr    = fetch_pc;
    req_fire         = imem_req_valid && imem_req_ready;
    rsp_take         = imem_rsp_valid && (outstanding != 2'd0);
    rsp_keep         = rsp_take && (drop_count == 2'd0);
    outstanding_next = outstanding + {1'b0, req_fire} - {1'b0, rsp_take};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      buf_head    <= 1'b0;
      buf_count   <= '0;
      inf_head    <= 1'b0;
      outstanding <= '0;
      drop_count  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_word[i] <= '0;
        buf_pc[i]   <= '0;
        inf_pc[i]   <= '0;
      end
    end else begin
      outstanding <= outstanding_next;
      if (rsp_take)
        inf_head <= ~inf_head;
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
        inf_pc[inf_head ^ outstanding[0]] <= fetch_pc;
      end
      if (redirect) begin
        // Every request still in flight after this edge belongs to the old path.
        fetch_pc   <= target;
        buf_count  <= '0;
        drop_count <= outstanding_next;
      end else begin
        if (rsp_take && (drop_count != 2'd0))
          drop_count <= drop_count - 2'd1;
        if (rsp_keep) begin
          buf_word[buf_head ^ buf_count[0]] <= imem_rsp_data;
          buf_pc[buf_head ^ buf_count[0]]   <= inf_pc[inf_head];
        end
        if (consume)
          buf_head <= ~buf_head;
        buf_count <= buf_count + {1'b0, rsp_keep} - {1'b0, consume};
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a queue-based fetch model, with a
// responding memory model and directed literal scenarios.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_ready;
  logic        br;
  logic [31:0] br_location;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc;

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .id_ready(id_ready), .br(br),
    .br_location(br_location), .instr_valid(instr_valid),
    .instruction(instruction), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] word; logic [31:0] pc; } bent_t;
  typedef struct { logic [31:0] pc; bit stale; } ient_t;
  typedef struct { logic [31:0] addr; int due; } ment_t;

  bent_t m_buf[$];
  ient_t m_inf[$];
  ment_t mem_q[$];
  logic [31:0] m_fetch;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  int id_pct, br_pct, rdy_pct, rsp_pct, lat_max, stray_pct;
  bit force_br;
  logic [31:0] force_loc;

  logic        s_iv, s_rv;
  logic [31:0] s_pc, s_addr;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst);
    bit cons, redir, exp_rv, exp_iv;
    logic [31:0] exp_ins, exp_pc;
    ient_t e;
    @(negedge clk);
    cyc++;
    reset       = rst;
    id_ready    = $urandom_range(99) < id_pct;
    br          = force_br ? 1'b1 : ($urandom_range(99) < br_pct);
    if (force_br) br_location = force_loc;
    else if ($urandom_range(3) == 0) br_location = 32'hFFFF_FFF0 | ($urandom & 32'hF);
    else br_location = $urandom & 32'h3FF;
    imem_req_ready = $urandom_range(99) < rdy_pct;
    if (rst) mem_q.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memword(mem_q[0].addr);
        void'(mem_q.pop_front());
      end
    end else if ($urandom_range(99) < stray_pct) begin
      imem_rsp_valid = 1'b1;
    end
    #1;
    if (rst) begin
      m_buf.delete();
      m_inf.delete();
      m_fetch = RST_PC;
    end
    exp_iv  = m_buf.size() != 0;
    exp_ins = exp_iv ? m_buf[0].word : NOP;
    exp_pc  = exp_iv ? m_buf[0].pc : 32'h0;
    cons    = !rst && exp_iv && id_ready;
    redir   = cons && br;
    exp_rv  = !rst && !redir && (m_buf.size() + m_inf.size() - int'(cons) < 2);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_iv});
    check("instruction", instruction, exp_ins);
    check("pc", pc, exp_pc);
    check("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) check("imem_req_addr", imem_req_addr, m_fetch);
    s_iv = instr_valid; s_rv = imem_req_valid; s_pc = pc; s_addr = imem_req_addr;
    if (!rst) begin
      if (cons) void'(m_buf.pop_front());
      if (imem_rsp_valid && m_inf.size() > 0) begin
        e = m_inf.pop_front();
        if (!e.stale && !redir) m_buf.push_back('{imem_rsp_data, e.pc});
      end
      if (redir) begin
        m_buf.delete();
        foreach (m_inf[i]) m_inf[i].stale = 1'b1;
        m_fetch = br_location & 32'hFFFF_FFFC;
      end else if (exp_rv && imem_req_ready) begin
        m_inf.push_back('{m_fetch, 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
      if (imem_req_valid && imem_req_ready)
        mem_q.push_back('{imem_req_addr, cyc + 1 + int'($urandom_range(lat_max - 1))});
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  task automatic directed_knobs(input int idp);
    id_pct = idp; br_pct = 0; rdy_pct = 100; rsp_pct = 100;
    lat_max = 1; stray_pct = 0; force_br = 1'b0; force_loc = '0;
  endtask

  initial begin
    reset = 1'b1; id_ready = 1'b0; br = 1'b0; br_location = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // Streaming fetch, then a taken branch to an unaligned target.
    directed_knobs(100);
    stray_pct = 100;
    step(1); step(1);
    step(0); lit("c0_rv", {31'b0, s_rv}, 1); lit("c0_addr", s_addr, 32'h0); lit("c0_iv", {31'b0, s_iv}, 0);
    stray_pct = 0;
    step(0); lit("c1_addr", s_addr, 32'h4); lit("c1_iv", {31'b0, s_iv}, 0);
    step(0); lit("c2_iv", {31'b0, s_iv}, 1); lit("c2_pc", s_pc, 32'h0); lit("c2_addr", s_addr, 32'h8);
    step(0); lit("c3_pc", s_pc, 32'h4);
    force_br = 1'b1; force_loc = 32'h0000_0103;
    step(0); lit("br_pc", s_pc, 32'h8); lit("br_rv", {31'b0, s_rv}, 0);
    force_br = 1'b0;
    step(0); lit("tgt_addr", s_addr, 32'h100); lit("tgt_iv", {31'b0, s_iv}, 0);
    step(0); lit("tgt_iv2", {31'b0, s_iv}, 0); lit("tgt_addr2", s_addr, 32'h104);
    step(0); lit("tgt_pc", s_pc, 32'h100);

    // Decode stall: buffer fills, requests stop, head held.
    directed_knobs(0);
    step(1);
    step(0); step(0); step(0);
    step(0); lit("stall_rv", {31'b0, s_rv}, 0); lit("stall_pc", s_pc, 32'h0);
    step(0); lit("stall_rv2", {31'b0, s_rv}, 0);
    id_pct = 100;
    step(0); lit("rel_pc0", s_pc, 32'h0); lit("rel_addr", s_addr, 32'h8);
    step(0); lit("rel_pc4", s_pc, 32'h4);
    step(0); lit("rel_pc8", s_pc, 32'h8);

    // Address wrap at the top of memory.
    directed_knobs(100);
    step(1);
    step(0); step(0);
    force_br = 1'b1; force_loc = 32'hFFFF_FFFB;
    step(0); force_br = 1'b0;
    step(0); lit("wrap_a0", s_addr, 32'hFFFF_FFF8);
    step(0); lit("wrap_a1", s_addr, 32'hFFFF_FFFC);
    step(0); lit("wrap_a2", s_addr, 32'h0); lit("wrap_pc", s_pc, 32'hFFFF_FFF8);

    // Randomized traffic with occasional mid-stream resets.
    for (int ph = 0; ph < 12; ph++) begin
      id_pct    = 30 + int'($urandom_range(70));
      rdy_pct   = 30 + int'($urandom_range(70));
      rsp_pct   = 40 + int'($urandom_range(60));
      lat_max   = 1 + int'($urandom_range(3));
      br_pct    = int'($urandom_range(15));
      stray_pct = 5;
      force_br  = 1'b0;
      for (int k = 0; k < 300; k++) begin
        if ($urandom_range(199) == 0) begin
          step(1);
          if ($urandom_range(1) == 1) step(1);
        end else begin
          step(0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
